// File: rtl/serial_feeder_pkg.sv
// Shared types and helpers for the serial bit feeder that drives the
// three-consecutive-1s detector.
package serial_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } feeder_state_t;

    localparam logic IDLE_LEVEL = 1'b0;

    // Width of the bit-position counter for a word of w bits.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-in / serial-out feeder: accepts words over valid/ready and emits
// one bit per clock, holding dout at the idle level between words.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    feeder_state_t    state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       gap_cnt;
    logic             at_last;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign at_last = (state == SHIFT) && (bit_cnt == LAST_IDX);

    // Handshake: a word transfers on any rising edge where data_valid and
    // data_ready are both high. data_ready is high in IDLE and, only when no
    // gap is configured, in the last-bit cycle so words can stream with no
    // bubble. It is forced low while reset is asserted.
    assign data_ready = !reset && ((state == IDLE) || ((GAP_CYCLES == 0) && at_last));
    assign accept     = data_valid && data_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            last_bit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SHIFT;
                        sr         <= advance(data_in);
                        dout       <= head(data_in);
                        dout_valid <= 1'b1;
                        bit_cnt    <= '0;
                        last_bit   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (at_last) begin
                        if (accept) begin
                            sr         <= advance(data_in);
                            dout       <= head(data_in);
                            dout_valid <= 1'b1;
                            bit_cnt    <= '0;
                            last_bit   <= 1'b0;
                        end else begin
                            state      <= (GAP_CYCLES > 0) ? GAP : IDLE;
                            gap_cnt    <= '0;
                            dout       <= IDLE_LEVEL;
                            dout_valid <= 1'b0;
                            last_bit   <= 1'b0;
                        end
                    end else begin
                        bit_cnt  <= bit_cnt + CW'(1);
                        dout     <= head(sr);
                        sr       <= advance(sr);
                        last_bit <= ((bit_cnt + CW'(1)) == LAST_IDX);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (LSB-first/no gap and
// MSB-first/3-cycle gap) checked against a queue-based stream model.
module tb_serial_bit_feeder;

    localparam int W     = 8;
    localparam int GAP_B = 3;

    typedef struct {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din_a, din_b;
    logic         dv_a, dv_b;
    logic         rdy_a, dout_a, dov_a, lb_a, busy_a;
    logic         rdy_b, dout_b, dov_b, lb_b, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   gap_pos = 0;
    bit   run     = 1'b0;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(0)) u_a (
        .clk(clk), .reset(reset), .data_in(din_a), .data_valid(dv_a),
        .data_ready(rdy_a), .dout(dout_a), .dout_valid(dov_a),
        .last_bit(lb_a), .busy(busy_a)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(GAP_B)) u_b (
        .clk(clk), .reset(reset), .data_in(din_b), .data_valid(dv_b),
        .data_ready(rdy_b), .dout(dout_b), .dout_valid(dov_b),
        .last_bit(lb_b), .busy(busy_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Bit k of the sending order is visible k cycles after the accept edge
    // (counted in posedges), i.e. in the cycle following edge accept_edge+k.
    task automatic push_expected(input bit which, input logic [W-1:0] w, input int accept_edge);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.b    = which ? w[W-1-k] : w[k];
            e.last = (k == W - 1);
            e.cyc  = accept_edge + k;
            if (which) q_b.push_back(e);
            else       q_a.push_back(e);
        end
    endtask

    // ---------------- driver ----------------
    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic send(input bit which, input logic [W-1:0] w);
        int  budget = 0;
        bit  ok     = 1'b1;
        if (which) begin din_b = w; dv_b = 1'b1; end
        else       begin din_a = w; dv_a = 1'b1; end
        while (!(which ? rdy_b : rdy_a)) begin
            @(negedge clk);
            budget++;
            if (budget > 300) begin
                check(which ? "b_accept_wait" : "a_accept_wait", {31'd0, which ? rdy_b : rdy_a}, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            push_expected(which, w, cyc + 1);
            @(negedge clk);
        end
        if (which) begin din_b = ~w; dv_b = 1'b0; end
        else       begin din_a = ~w; dv_a = 1'b0; end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input bit which, input logic d, input logic dv, input logic lb,
                       input logic rdy, input logic bsy);
        exp_t  e;
        int    n;
        string p;
        p = which ? "b_" : "a_";
        n = which ? q_b.size() : q_a.size();
        if (dv) begin
            check({p, "busy_while_valid"}, {31'd0, bsy}, 32'd1);
            if (n == 0) begin
                check({p, "valid_without_word"}, {31'd0, dv}, 32'd0);
            end else begin
                e = which ? q_b.pop_front() : q_a.pop_front();
                check({p, "bit_and_last"}, {30'd0, d, lb}, {30'd0, e.b, e.last});
                check({p, "bit_cycle"}, cyc, e.cyc);
            end
        end else begin
            check({p, "idle_level"}, {31'd0, d}, 32'd0);
            if (n > 0) begin
                e = which ? q_b[0] : q_a[0];
                if (e.cyc <= cyc) begin
                    check({p, "missing_bit"}, {31'd0, dv}, 32'd1);
                    if (which) void'(q_b.pop_front());
                    else       void'(q_a.pop_front());
                end
            end
        end
        if (!which) begin
            if (lb) check("a_ready_on_last_bit", {31'd0, rdy}, 32'd1);
        end else begin
            if (gap_pos >= 1 && gap_pos <= GAP_B) begin
                check("b_gap_cycle", {29'd0, dv, rdy, bsy}, 32'b001);
                gap_pos++;
            end else if (gap_pos == GAP_B + 1) begin
                check("b_idle_after_gap", {30'd0, rdy, bsy}, 32'b10);
                gap_pos = 0;
            end
            if (lb) gap_pos = 1;
        end
    endtask

    always @(negedge clk) begin
        if (run && !reset) begin
            mon(1'b0, dout_a, dov_a, lb_a, rdy_a, busy_a);
            mon(1'b1, dout_b, dov_b, lb_b, rdy_b, busy_b);
        end
    end

    task automatic drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        repeat (GAP_B + 3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        din_a = '0; din_b = '0;
        dv_a  = 1'b1; dv_b = 1'b1;
        #8;
        check("a_reset_outputs", {27'd0, rdy_a, dout_a, dov_a, lb_a, busy_a}, 32'd0);
        check("b_reset_outputs", {27'd0, rdy_b, dout_b, dov_b, lb_b, busy_b}, 32'd0);
        #3;
        dv_a = 1'b0; dv_b = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        run = 1'b1;
        check("a_ready_after_reset", {29'd0, rdy_a, dov_a, busy_a}, 32'b100);
        check("b_ready_after_reset", {29'd0, rdy_b, dov_b, busy_b}, 32'b100);

        // Directed: single word, back-to-back pair, gap pair, MSB-first word.
        fork
            begin
                send(1'b0, 8'hDE);
                send(1'b0, 8'hC0);
                send(1'b0, 8'h03);
            end
            begin
                send(1'b1, 8'hFF);
                send(1'b1, 8'hFF);
                send(1'b1, 8'h81);
            end
        join
        drain();

        // Reset during bit 4 of a word, then a fresh word.
        send(1'b0, 8'hFF);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("a_midword_reset", {27'd0, rdy_a, dout_a, dov_a, lb_a, busy_a}, 32'd0);
        q_a.delete();
        q_b.delete();
        gap_pos = 0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        send(1'b0, 8'h0F);
        drain();

        // Randomized traffic on both instances.
        fork
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(1'b0, W'($urandom));
            end
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(1'b1, W'($urandom));
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
